multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 i_rst_n  in  1  asynchronous active-low reset.
REQ-003 i_instr  in  32  instruction register contents; opcode [6:0], funct3 [14:12], funct7 [31:25].
REQ-004 i_imem_ready  in  1  instruction memory accepts the request and returns data this cycle.
REQ-005 i_dmem_ready  in  1  data memory completes the access this cycle.
REQ-006 i_br_taken  in  1  branch comparison result, valid in EXEC.
REQ-007 o_imem_req  out  1  instruction fetch request.
REQ-008 o_ir_en  out  1  load instruction register.
REQ-009 o_pc_en  out  1  update PC.
REQ-010 o_pc_sel  out  1  0 = PC+4, 1 = ALU target.
REQ-011 o_dmem_req / o_dmem_wren  out  1/1  data access request / write strobe.
REQ-012 o_rd_wren  out  1  register-file write.
REQ-013 o_wb_sel  out  2  00 ALU, 01 memory, 10 PC+4.
REQ-014 o_opa_sel  out  2  00 rs1, 01 PC, 10 zero.
REQ-015 o_opb_sel  out  1  0 rs2, 1 imm.
REQ-016 o_alu_op  out  4  ALU operation code: ADD 0000 … AND 1001, LUI 1010, NOP 1111.
REQ-017 o_retire  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-018 o_illegal  out  1  sticky illegal-opcode flag.
REQ-019 o_retire_cnt  out  32  retired-instruction count.

Function
REQ-020 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-021 FETCH: o_imem_req=1 until i_imem_ready=1; o_ir_en=1 only in the ready cycle; then go to DECODE.
REQ-022 DECODE: no strobes; supported opcode -> EXEC; any other opcode -> TRAP.
REQ-023 EXEC: o_opa_sel/o_opb_sel/o_alu_op drive per opcode.
REQ-024 EXEC exit by class: R/I-ALU, LUI, AUIPC, JAL, JALR -> WB; LOAD, STORE -> MEM; BRANCH retires in EXEC -> FETCH.
REQ-025 BRANCH: o_pc_en=1; o_pc_sel=i_br_taken.
REQ-026 MEM: o_dmem_req=1 (o_dmem_wren=1 for STORE) held with stable selects until i_dmem_ready=1.
REQ-027 On i_dmem_ready in MEM: LOAD -> WB; STORE retires (o_pc_en=1, o_pc_sel=0) -> FETCH.
REQ-028 WB: o_rd_wren=1 for one cycle.
REQ-029 WB o_wb_sel: 01 LOAD, 10 JAL/JALR, else 00.
REQ-030 WB PC update: o_pc_en=1; o_pc_sel=1 for JAL/JALR, else 0; then -> FETCH.
REQ-031 Zero-wait latency in cycles: ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3; each ready-low cycle adds exactly one.
REQ-032 o_retire pulses exactly in the cycle o_pc_en=1; o_retire_cnt increments on that edge and wraps 0xFFFFFFFF -> 0.
REQ-033 TRAP: o_illegal=1; all strobes stay 0; no exit except reset.
REQ-034 Strobes (req, wren, ir_en, pc_en, rd_wren, retire) are 0 in every state not listed above for them.
REQ-035 Outputs are Moore-style from state plus the latched instruction; i_*_ready affects transitions and ir_en/pc_en only.

Reset
REQ-036 Asserting i_rst_n low forces FETCH immediately.
REQ-037 Reset clears o_illegal and o_retire_cnt to 0; all strobes 0; o_wb_sel=00, o_opa_sel=00, o_opb_sel=0, o_alu_op=1111.
REQ-038 Reset mid-MEM or mid-FETCH drops the request combinationally; the pending access is abandoned, and the first post-reset cycle asserts o_imem_req.

Structure
REQ-039 Shared package rv_ctrl_pkg holds the state enum, opcode constants, alu_op codes, wb_sel and opa_sel encodings.
REQ-040 One combinational sub-module, alu_op_dec: opcode/funct3/funct7 -> o_alu_op. BRANCH -> SUB 0001; JAL/JALR -> ADD 0000.

Verification
REQ-041 ADD x3,x1,x2 (0x002081B3), both ready=1 -> rd_wren in cycle 4, wb_sel=00, alu_op=0000, retire_cnt 0->1.
REQ-042 LW (0x0000A183), dmem_ready low 3 cycles -> dmem_req held 4 cycles, wren=0, retire at cycle 8, wb_sel=01.
REQ-043 BEQ (0x00208463): i_br_taken=1 -> pc_en, pc_sel=1 at cycle 3; i_br_taken=0 -> pc_sel=0; no rd_wren in either case.
REQ-044 Opcode 0x7F -> o_illegal=1 from cycle 3 and held 20 cycles with no strobes; i_rst_n pulse -> o_illegal=0, FETCH.
REQ-045 Preload retire_cnt to 0xFFFFFFFF (force), retire one SW (0x0020A023) -> count 0, dmem_wren=1 in MEM.
REQ-046 Assert i_rst_n low during a SW's MEM wait -> dmem_req=0 at once, retire_cnt=0, next cycle imem_req=1.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Holds FSM states, opcodes, ALU op codes, datapath select encodings and decode helpers.
package rv_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned CNT_W    = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001,
    ALU_LUI  = 4'b1010,
    ALU_NOP  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_ZERO = 2'b10
  } opa_sel_e;

  typedef enum logic [3:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } instr_cls_e;

  function automatic instr_cls_e decode_class(input logic [6:0] opc);
    instr_cls_e cls;
    cls = CLS_ILLEGAL;
    case (opc)
      OPC_OP:     cls = CLS_ALU_R;
      OPC_OP_IMM: cls = CLS_ALU_I;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_e funct3_alu_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// Combinational ALU operation decode from opcode, funct3 and funct7.
module alu_op_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_funct3,
  input  logic [6:0]          i_funct7,
  output logic [ALU_OP_W-1:0] o_alu_op
);

  alu_op_e op_c;
  logic    unused_funct7;

  assign unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};

  // Immediate forms never subtract; only shift-right uses funct7[5]
  always_comb begin
    op_c = ALU_NOP;
    case (i_opcode)
      OPC_OP:     op_c = funct3_alu_op(i_funct3, i_funct7[5]);
      OPC_OP_IMM: op_c = funct3_alu_op(i_funct3, (i_funct3 == 3'b101) && i_funct7[5]);
      OPC_LUI:    op_c = ALU_LUI;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: op_c = ALU_ADD;
      OPC_BRANCH: op_c = ALU_SUB;
      default:    op_c = ALU_NOP;
    endcase
  end

  assign o_alu_op = op_c;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
// Strobes are decoded from state and the instruction register; reset masks them immediately.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [XLEN-1:0]     i_instr,
  input  logic                i_imem_ready,
  input  logic                i_dmem_ready,
  input  logic                i_br_taken,
  output logic                o_imem_req,
  output logic                o_ir_en,
  output logic                o_pc_en,
  output logic                o_pc_sel,
  output logic                o_dmem_req,
  output logic                o_dmem_wren,
  output logic                o_rd_wren,
  output logic [1:0]          o_wb_sel,
  output logic [1:0]          o_opa_sel,
  output logic                o_opb_sel,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_retire,
  output logic                o_illegal,
  output logic [CNT_W-1:0]    o_retire_cnt
);

  state_e                state_q, state_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;

  instr_cls_e            cls_c;
  logic [ALU_OP_W-1:0]   alu_op_dec_c;
  opa_sel_e              opa_dp_c;
  logic                  opb_dp_c;

  logic                  imem_req_c, ir_en_c, pc_en_c, pc_sel_c;
  logic                  dmem_req_c, dmem_wren_c, rd_wren_c;
  wb_sel_e               wb_sel_c;
  opa_sel_e              opa_sel_c;
  logic                  opb_sel_c;
  logic [ALU_OP_W-1:0]   alu_op_c;
  logic                  unused_instr;

  assign unused_instr = ^{i_instr[24:15], i_instr[11:7]};
  assign cls_c        = decode_class(i_instr[6:0]);

  alu_op_dec u_alu_op_dec (
    .i_opcode (i_instr[6:0]),
    .i_funct3 (i_instr[14:12]),
    .i_funct7 (i_instr[31:25]),
    .o_alu_op (alu_op_dec_c)
  );

  // Operand selects for the latched instruction, applied in EXEC/MEM/WB
  always_comb begin
    opa_dp_c = OPA_RS1;
    opb_dp_c = 1'b1;
    case (cls_c)
      CLS_LUI:            opa_dp_c = OPA_ZERO;
      CLS_AUIPC, CLS_JAL: opa_dp_c = OPA_PC;
      default:            opa_dp_c = OPA_RS1;
    endcase
    if ((cls_c == CLS_ALU_R) || (cls_c == CLS_BRANCH)) begin
      opb_dp_c = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    imem_req_c  = 1'b0;
    ir_en_c     = 1'b0;
    pc_en_c     = 1'b0;
    pc_sel_c    = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_wren_c = 1'b0;
    rd_wren_c   = 1'b0;
    wb_sel_c    = WB_ALU;
    opa_sel_c   = OPA_RS1;
    opb_sel_c   = 1'b0;
    alu_op_c    = ALU_NOP;

    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (i_imem_ready) begin
          ir_en_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls_c == CLS_ILLEGAL) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        opa_sel_c = opa_dp_c;
        opb_sel_c = opb_dp_c;
        alu_op_c  = alu_op_dec_c;
        case (cls_c)
          CLS_BRANCH: begin
            pc_en_c  = 1'b1;
            pc_sel_c = i_br_taken;
            state_d  = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        opa_sel_c   = opa_dp_c;
        opb_sel_c   = opb_dp_c;
        alu_op_c    = alu_op_dec_c;
        dmem_req_c  = 1'b1;
        dmem_wren_c = (cls_c == CLS_STORE);
        if (i_dmem_ready) begin
          if (cls_c == CLS_STORE) begin
            pc_en_c = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        opa_sel_c = opa_dp_c;
        opb_sel_c = opb_dp_c;
        alu_op_c  = alu_op_dec_c;
        rd_wren_c = 1'b1;
        pc_en_c   = 1'b1;
        if (cls_c == CLS_LOAD) begin
          wb_sel_c = WB_MEM;
        end else if ((cls_c == CLS_JAL) || (cls_c == CLS_JALR)) begin
          wb_sel_c = WB_PC4;
          pc_sel_c = 1'b1;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    retire_cnt_d = retire_cnt_q + CNT_W'(pc_en_c);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_FETCH;
      illegal_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      illegal_q    <= illegal_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Reset masks every strobe at once so an in-flight access is dropped
  assign o_imem_req   = imem_req_c  & i_rst_n;
  assign o_ir_en      = ir_en_c     & i_rst_n;
  assign o_pc_en      = pc_en_c     & i_rst_n;
  assign o_retire     = pc_en_c     & i_rst_n;
  assign o_dmem_req   = dmem_req_c  & i_rst_n;
  assign o_dmem_wren  = dmem_wren_c & i_rst_n;
  assign o_rd_wren    = rd_wren_c   & i_rst_n;
  assign o_pc_sel     = pc_sel_c;
  assign o_wb_sel     = wb_sel_c;
  assign o_opa_sel    = opa_sel_c;
  assign o_opb_sel    = opb_sel_c;
  assign o_alu_op     = alu_op_c;
  assign o_illegal    = illegal_q;
  assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle traces built
// from the instruction class and wait counts, compared every cycle, plus literal pins.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, br_taken;
  logic        o_imem_req, o_ir_en, o_pc_en, o_pc_sel, o_dmem_req, o_dmem_wren, o_rd_wren;
  logic [1:0]  o_wb_sel, o_opa_sel;
  logic        o_opb_sel;
  logic [3:0]  o_alu_op;
  logic        o_retire, o_illegal;
  logic [31:0] o_retire_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_instr      (instr),
    .i_imem_ready (imem_ready),
    .i_dmem_ready (dmem_ready),
    .i_br_taken   (br_taken),
    .o_imem_req   (o_imem_req),
    .o_ir_en      (o_ir_en),
    .o_pc_en      (o_pc_en),
    .o_pc_sel     (o_pc_sel),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_wren  (o_dmem_wren),
    .o_rd_wren    (o_rd_wren),
    .o_wb_sel     (o_wb_sel),
    .o_opa_sel    (o_opa_sel),
    .o_opb_sel    (o_opb_sel),
    .o_alu_op     (o_alu_op),
    .o_retire     (o_retire),
    .o_illegal    (o_illegal),
    .o_retire_cnt (o_retire_cnt)
  );

  typedef struct packed {
    logic        imem_req, ir_en, pc_en, pc_sel, dmem_req, dmem_wren, rd_wren;
    logic [1:0]  wb_sel;
    logic [1:0]  opa_sel;
    logic        opb_sel;
    logic [3:0]  alu_op;
    logic        retire, illegal;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        imem_ready, dmem_ready, br_taken;
    exp_t        e;
  } cyc_t;

  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4, K_JALR = 5;
  localparam int K_LOAD = 6, K_STORE = 7, K_BR = 8, K_BAD = 9;

  cyc_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_cnt;
  logic        m_ill;
  int          retire_at, rdw_at, dmem_cyc, wren_cyc;

  function automatic int kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h37:   return K_LUI;
      7'h17:   return K_AUIPC;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      7'h03:   return K_LOAD;
      7'h23:   return K_STORE;
      7'h63:   return K_BR;
      default: return K_BAD;
    endcase
  endfunction

  function automatic exp_t idle();
    exp_t e;
    e         = '0;
    e.alu_op  = 4'hF;
    e.cnt     = m_cnt;
    e.illegal = m_ill;
    return e;
  endfunction

  // Operand/ALU selects an instruction needs while it is in the datapath
  function automatic exp_t with_sel(input exp_t e_in, input logic [31:0] ins);
    exp_t       e;
    logic [3:0] tbl [8];
    logic [2:0] f3;
    logic       alt;
    e   = e_in;
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f3  = ins[14:12];
    alt = ins[30];
    case (kind_of(ins))
      K_R: begin
        e.alu_op = tbl[f3];
        if (f3 == 3'd0 && alt) e.alu_op = 4'd1;
        if (f3 == 3'd5 && alt) e.alu_op = 4'd7;
        e.opa_sel = 2'd0; e.opb_sel = 1'b0;
      end
      K_I: begin
        e.alu_op = tbl[f3];
        if (f3 == 3'd5 && alt) e.alu_op = 4'd7;
        e.opa_sel = 2'd0; e.opb_sel = 1'b1;
      end
      K_LUI:          begin e.alu_op = 4'hA; e.opa_sel = 2'd2; e.opb_sel = 1'b1; end
      K_AUIPC, K_JAL: begin e.alu_op = 4'h0; e.opa_sel = 2'd1; e.opb_sel = 1'b1; end
      K_BR:           begin e.alu_op = 4'h1; e.opa_sel = 2'd0; e.opb_sel = 1'b0; end
      default:        begin e.alu_op = 4'h0; e.opa_sel = 2'd0; e.opb_sel = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t dut_vec();
    exp_t v;
    v.imem_req = o_imem_req;  v.ir_en = o_ir_en;   v.pc_en = o_pc_en;
    v.pc_sel = o_pc_sel;      v.dmem_req = o_dmem_req; v.dmem_wren = o_dmem_wren;
    v.rd_wren = o_rd_wren;    v.wb_sel = o_wb_sel; v.opa_sel = o_opa_sel;
    v.opb_sel = o_opb_sel;    v.alu_op = o_alu_op; v.retire = o_retire;
    v.illegal = o_illegal;    v.cnt = o_retire_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic ir, input logic dr,
                      input logic bt, input exp_t e);
    cyc_t c;
    c.ins = ins; c.imem_ready = ir; c.dmem_ready = dr; c.br_taken = bt; c.e = e;
    q.push_back(c);
  endtask

  // Expected trace of one instruction: fw fetch stalls, mw memory stalls
  task automatic add_instr(input logic [31:0] ins, input int fw, input int mw, input logic br);
    exp_t e;
    int   k;
    k = kind_of(ins);
    for (int i = 0; i < fw; i++) begin
      e = idle(); e.imem_req = 1'b1;
      push(ins, 1'b0, rbit(), rbit(), e);
    end
    e = idle(); e.imem_req = 1'b1; e.ir_en = 1'b1;
    push(ins, 1'b1, rbit(), rbit(), e);
    push(ins, rbit(), rbit(), rbit(), idle());
    if (k == K_BAD) begin
      m_ill = 1'b1;
      for (int i = 0; i < 20; i++) push(ins, rbit(), rbit(), rbit(), idle());
      return;
    end
    e = with_sel(idle(), ins);
    if (k == K_BR) begin
      e.pc_en = 1'b1; e.pc_sel = br; e.retire = 1'b1;
      push(ins, rbit(), rbit(), br, e);
      m_cnt = m_cnt + 32'd1;
      return;
    end
    push(ins, rbit(), rbit(), rbit(), e);
    if (k == K_LOAD || k == K_STORE) begin
      e = with_sel(idle(), ins); e.dmem_req = 1'b1; e.dmem_wren = (k == K_STORE);
      for (int i = 0; i < mw; i++) push(ins, rbit(), 1'b0, rbit(), e);
      if (k == K_STORE) begin
        e.pc_en = 1'b1; e.retire = 1'b1;
        push(ins, rbit(), 1'b1, rbit(), e);
        m_cnt = m_cnt + 32'd1;
        return;
      end
      push(ins, rbit(), 1'b1, rbit(), e);
    end
    e = with_sel(idle(), ins);
    e.rd_wren = 1'b1; e.pc_en = 1'b1; e.retire = 1'b1;
    e.pc_sel  = (k == K_JAL || k == K_JALR);
    e.wb_sel  = (k == K_LOAD) ? 2'b01 : ((k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00);
    push(ins, rbit(), rbit(), rbit(), e);
    m_cnt = m_cnt + 32'd1;
  endtask

  // Compare process: entered at a negedge, drives each cycle and checks outputs
  task automatic run_queue(input int max_items);
    cyc_t c;
    int   n;
    n = 0; retire_at = 0; rdw_at = 0; dmem_cyc = 0; wren_cyc = 0;
    while (q.size() > 0 && n < max_items) begin
      c = q.pop_front();
      n++;
      instr = c.ins; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready; br_taken = c.br_taken;
      #1;
      chk($sformatf("cycle%0d_ins%h", n, c.ins), 64'(dut_vec()), 64'(c.e));
      if (o_retire && retire_at == 0) retire_at = n;
      if (o_rd_wren && rdw_at == 0) rdw_at = n;
      if (o_dmem_req) dmem_cyc++;
      if (o_dmem_wren) wren_cyc++;
      @(negedge clk);
    end
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
    m_cnt = 32'd0; m_ill = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 64'(dut_vec()), 64'(idle()));
    chk("reset_alu_op", 64'(o_alu_op), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;

    add_instr(32'h002081B3, 0, 0, 1'b0);          // ADD x3,x1,x2
    run_queue(1000);
    chk("add_rd_wren_cycle", 64'(rdw_at), 64'd4);
    chk("add_retire_cnt", 64'(o_retire_cnt), 64'd1);

    add_instr(32'h0000A183, 0, 3, 1'b0);          // LW with 3 wait cycles
    run_queue(1000);
    chk("lw_retire_cycle", 64'(retire_at), 64'd8);
    chk("lw_dmem_req_cycles", 64'(dmem_cyc), 64'd4);
    chk("lw_wren_cycles", 64'(wren_cyc), 64'd0);

    add_instr(32'h00208463, 0, 0, 1'b1);          // BEQ taken
    run_queue(1000);
    chk("beq_t_retire_cycle", 64'(retire_at), 64'd3);
    chk("beq_t_no_rd_wren", 64'(rdw_at), 64'd0);
    add_instr(32'h00208463, 0, 0, 1'b0);          // BEQ not taken
    run_queue(1000);
    chk("beq_nt_retire_cycle", 64'(retire_at), 64'd3);
    chk("beq_nt_no_rd_wren", 64'(rdw_at), 64'd0);

    add_instr(32'h40208133, 2, 0, 1'b0);          // SUB with fetch stalls
    run_queue(1000);
    chk("sub_retire_cycle", 64'(retire_at), 64'd6);
    add_instr(32'hC0000093, 0, 0, 1'b0);          // ADDI imm bit30 set stays ADD
    add_instr(32'h4030D093, 1, 0, 1'b0);          // SRAI
    add_instr(32'h123450B7, 0, 0, 1'b0);          // LUI
    add_instr(32'h00001097, 0, 0, 1'b0);          // AUIPC
    add_instr(32'h008000EF, 0, 0, 1'b0);          // JAL
    add_instr(32'h000080E7, 0, 0, 1'b0);          // JALR
    add_instr(32'h0020A023, 0, 2, 1'b0);          // SW with 2 wait cycles
    run_queue(1000);
    chk("sw_wren_cycles", 64'(wren_cyc), 64'd3);
    chk("mix_retire_cnt", 64'(o_retire_cnt), 64'd12);

    imem_ready = 1'b0;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.retire_cnt_q;
    @(negedge clk);
    m_cnt = 32'hFFFF_FFFF;
    chk("preload_cnt", 64'(o_retire_cnt), 64'hFFFF_FFFF);
    add_instr(32'h0020A023, 0, 0, 1'b0);          // SW retiring across the wrap
    run_queue(1000);
    chk("wrap_cnt", 64'(o_retire_cnt), 64'd0);
    chk("wrap_sw_wren", 64'(wren_cyc), 64'd1);

    add_instr(32'h002081B3, 0, 0, 1'b0);
    run_queue(1000);
    add_instr(32'h0020A023, 0, 5, 1'b0);          // SW interrupted by reset in MEM
    run_queue(5);
    dmem_ready = 1'b0;
    #1;
    chk("mem_req_pre_rst", 64'(o_dmem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mem_req_in_rst", 64'(o_dmem_req), 64'd0);
    chk("imem_req_in_rst", 64'(o_imem_req), 64'd0);
    chk("cnt_in_rst", 64'(o_retire_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b0;
    #1;
    chk("imem_req_post_rst", 64'(o_imem_req), 64'd1);
    m_cnt = 32'd0; m_ill = 1'b0;
    @(negedge clk);

    add_instr(32'h0000007F, 1, 0, 1'b0);          // illegal opcode
    run_queue(1000);
    chk("illegal_sticky", 64'(o_illegal), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("illegal_cleared", 64'(o_illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b0;
    #1;
    chk("fetch_after_trap", 64'(o_imem_req), 64'd1);
    m_cnt = 32'd0; m_ill = 1'b0;
    @(negedge clk);
    add_instr(32'h002081B3, 0, 0, 1'b0);
    run_queue(1000);
    chk("add_after_trap_cnt", 64'(o_retire_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
